// File: rtl/gpio_cfg_chain_master_if.sv
// Host and pad-chain signal bundle for gpio_cfg_chain_master.
// master = the chain master block, slave = the register bank / chain side.
interface gpio_cfg_chain_master_if #(
  parameter int NUM_PADS      = 14,
  parameter int PAD_CTRL_BITS = 16
);
  localparam int AW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;

  logic                     cfg_wr;
  logic [AW-1:0]            cfg_addr;
  logic [PAD_CTRL_BITS-1:0] cfg_wdata;
  logic [PAD_CTRL_BITS-1:0] cfg_rdata;
  logic [PAD_CTRL_BITS-1:0] rb_rdata;
  logic                     start;
  logic                     chain_clr;
  logic                     busy;
  logic                     done;
  logic                     cfg_err;
  logic                     serial_clock;
  logic                     serial_load;
  logic                     serial_data_out;
  logic                     serial_data_in;
  logic                     serial_shift_rstn;

  modport master (
    input  cfg_wr, cfg_addr, cfg_wdata, start, chain_clr, serial_data_in,
    output cfg_rdata, rb_rdata, busy, done, cfg_err,
           serial_clock, serial_load, serial_data_out, serial_shift_rstn
  );

  modport slave (
    output cfg_wr, cfg_addr, cfg_wdata, start, chain_clr, serial_data_in,
    input  cfg_rdata, rb_rdata, busy, done, cfg_err,
           serial_clock, serial_load, serial_data_out, serial_shift_rstn
  );
endinterface

// File: rtl/gpio_cfg_chain_master.sv
// Pad-configuration chain master: shadow words per pad, shifted out last pad
// first / MSB first on a divided serial clock, committed with serial_load,
// with the chain's previous contents captured into a readback buffer.
// Needs NUM_PADS*PAD_CTRL_BITS >= 3.
module gpio_cfg_chain_master #(
  parameter int                       NUM_PADS      = 14,
  parameter int                       PAD_CTRL_BITS = 16,
  parameter logic [PAD_CTRL_BITS-1:0] GPIO_DEFAULTS = PAD_CTRL_BITS'(16'h3000),
  parameter int                       CLK_DIV       = 2
) (
  input  logic                    mclk,
  input  logic                    reset,
  gpio_cfg_chain_master_if.master bus
);
  localparam int TOTAL = NUM_PADS * PAD_CTRL_BITS;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int AW    = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TOTAL - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [AW:0]      NP_LIM   = (AW + 1)'(NUM_PADS);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOAD, S_CLR} state_t;

  typedef logic [NUM_PADS-1:0][PAD_CTRL_BITS-1:0] image_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  // Bits still to be sent; the bit currently on serial_data_out is not kept here.
  logic [TOTAL-2:0]  image_q, image_d;
  logic [TOTAL-1:0]  rb_sr_q, rb_sr_d;
  image_t            shadow_q, shadow_d;
  image_t            rb_q, rb_d;
  logic [TOTAL-1:0]  shadow_flat;
  logic              sclk_q, sclk_d;
  logic              load_q, load_d;
  logic              sdo_q, sdo_d;
  logic              rstn_q, rstn_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              addr_ok;
  logic              div_last;

  assign addr_ok  = ({1'b0, bus.cfg_addr} < NP_LIM);
  assign div_last = (div_q == DIV_LAST);

  assign bus.cfg_rdata         = addr_ok ? shadow_q[bus.cfg_addr] : '0;
  assign bus.rb_rdata          = addr_ok ? rb_q[bus.cfg_addr]     : '0;
  assign bus.serial_clock      = sclk_q;
  assign bus.serial_load       = load_q;
  assign bus.serial_data_out   = sdo_q;
  assign bus.serial_shift_rstn = rstn_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.cfg_err           = err_q;

  // Next-state, shadow write, shift datapath and registered outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    image_d  = image_q;
    rb_sr_d  = rb_sr_q;
    rb_d     = rb_q;
    shadow_d = shadow_q;
    sdo_d    = sdo_q;
    done_d   = 1'b0;
    err_d    = busy_q & (bus.cfg_wr | bus.start | bus.chain_clr);

    // Write lands before the image snapshot so a same-cycle start sees it.
    if (bus.cfg_wr && (state_q == S_IDLE) && addr_ok)
      shadow_d[bus.cfg_addr] = bus.cfg_wdata;
    shadow_flat = shadow_d;

    case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (bus.chain_clr) begin
          state_d = S_CLR;
        end else if (bus.start) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          sdo_d   = shadow_flat[TOTAL-1];
          image_d = shadow_flat[TOTAL-2:0];
        end
      end
      S_SETUP: begin
        if (div_last) begin
          state_d = S_HIGH;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (div_last) begin
          // Sample the returning bit as late as possible in the high phase.
          rb_sr_d = {rb_sr_q[TOTAL-2:0], bus.serial_data_in};
          div_d   = '0;
          if (cnt_q == LAST_BIT) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_SETUP;
            cnt_d   = cnt_q + 1'b1;
            sdo_d   = image_q[TOTAL-2];
            image_d = {image_q[TOTAL-3:0], 1'b0};
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_LOAD: begin
        if (div_last) begin
          state_d = S_IDLE;
          div_d   = '0;
          done_d  = 1'b1;
          rb_d    = rb_sr_q;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_CLR: begin
        if (div_last) begin
          state_d = S_IDLE;
          div_d   = '0;
          done_d  = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        div_d   = '0;
      end
    endcase

    sclk_d = (state_d == S_HIGH);
    load_d = (state_d == S_LOAD);
    rstn_d = (state_d != S_CLR);
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any sequence in progress.
  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      image_q  <= '0;
      rb_sr_q  <= '0;
      shadow_q <= {NUM_PADS{GPIO_DEFAULTS}};
      rb_q     <= '0;
      sclk_q   <= 1'b0;
      load_q   <= 1'b0;
      sdo_q    <= 1'b0;
      rstn_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      image_q  <= image_d;
      rb_sr_q  <= rb_sr_d;
      shadow_q <= shadow_d;
      rb_q     <= rb_d;
      sclk_q   <= sclk_d;
      load_q   <= load_d;
      sdo_q    <= sdo_d;
      rstn_q   <= rstn_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_gpio_cfg_chain_master.sv
// Directed bench for gpio_cfg_chain_master: 2 pads x 4 bits, CLK_DIV=1.
module tb_gpio_cfg_chain_master;
  localparam int NP  = 2;
  localparam int PCB = 4;
  localparam int CD  = 1;

  logic mclk  = 1'b0;
  logic reset = 1'b1;
  always #5 mclk = ~mclk;

  gpio_cfg_chain_master_if #(.NUM_PADS(NP), .PAD_CTRL_BITS(PCB)) bus();

  gpio_cfg_chain_master #(.NUM_PADS(NP), .PAD_CTRL_BITS(PCB), .CLK_DIV(CD)) dut (
    .mclk  (mclk),
    .reset (reset),
    .bus   (bus)
  );

  // Chain model: 8-bit shift register, first-in bit ends at the MSB side.
  // It advances at the end of each high phase, after the master sampled it.
  logic [7:0] chain;
  logic       pre_en;
  logic [7:0] pre_val;
  always @(posedge mclk) begin
    if (pre_en)                 chain <= pre_val;
    else if (bus.serial_clock)  chain <= {chain[6:0], bus.serial_data_out};
  end
  assign bus.serial_data_in = chain[7];

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] m_busy, m_load, m_done, m_err, m_sclk, m_clr;
  logic [7:0]  sbits;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic rd(input int a, output logic [3:0] cfg, output logic [3:0] rb);
    bus.cfg_addr = a[0];
    #1;
    cfg = bus.cfg_rdata;
    rb  = bus.rb_rdata;
  endtask

  // Drive inputs for cycles 0..ncyc-1 and record outputs seen in cycles 1..ncyc.
  task automatic run(input bit do_start, input bit do_clr, input int wr_at,
                     input int rst_at, input int ncyc);
    m_busy = '0; m_load = '0; m_done = '0; m_err = '0; m_sclk = '0; m_clr = '0;
    sbits  = '0;
    for (int j = 0; j < ncyc; j++) begin
      bus.start     = do_start && (j == 0);
      bus.chain_clr = do_clr && (j == 0);
      bus.cfg_wr    = (j == wr_at);
      reset         = (j == rst_at);
      tick();
      m_busy[j+1] = bus.busy;
      m_load[j+1] = bus.serial_load;
      m_done[j+1] = bus.done;
      m_err[j+1]  = bus.cfg_err;
      m_sclk[j+1] = bus.serial_clock;
      m_clr[j+1]  = ~bus.serial_shift_rstn;
      if (bus.serial_clock) sbits = {sbits[6:0], bus.serial_data_out};
    end
    bus.start = 1'b0; bus.chain_clr = 1'b0; bus.cfg_wr = 1'b0; reset = 1'b0;
  endtask

  logic [3:0] c, r;

  initial begin
    bus.cfg_wr = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    bus.start = 1'b0; bus.chain_clr = 1'b0;
    pre_en = 1'b0; pre_val = '0;

    // Reset state
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_rstn", bus.serial_shift_rstn, 1);
    chk("rst_sclk", bus.serial_clock, 0);
    chk("rst_load", bus.serial_load, 0);
    chk("rst_done", bus.done, 0);
    rd(0, c, r); chk("rst_cfg0", c, 4'h0); chk("rst_rb0", r, 4'h0);
    rd(1, c, r); chk("rst_cfg1", c, 4'h0);

    // Shadow writes
    bus.cfg_wr = 1'b1; bus.cfg_addr = 1'b1; bus.cfg_wdata = 4'hA; tick();
    bus.cfg_addr = 1'b0; bus.cfg_wdata = 4'h5; tick();
    bus.cfg_wr = 1'b0;
    rd(1, c, r); chk("wr_cfg1", c, 4'hA);
    rd(0, c, r); chk("wr_cfg0", c, 4'h5);

    // Preload the chain with 3/C, then shift A/5 in
    pre_en = 1'b1; pre_val = 8'h3C; tick(); pre_en = 1'b0;
    run(1'b1, 1'b0, -1, -1, 20);
    chk("sh_bits", sbits, 8'hA5);
    chk("sh_sclk", m_sclk, 32'h15554);
    chk("sh_load", m_load, 32'h20000);
    chk("sh_done", m_done, 32'h40000);
    chk("sh_busy", m_busy, 32'h3FFFE);
    chk("sh_err",  m_err,  32'h0);
    chk("sh_clr",  m_clr,  32'h0);
    chk("sh_chain", chain, 8'hA5);
    rd(1, c, r); chk("sh_rb1", r, 4'h3);
    rd(0, c, r); chk("sh_rb0", r, 4'hC);

    // cfg_wr while busy is dropped with an error pulse
    bus.cfg_addr = 1'b0; bus.cfg_wdata = 4'hF;
    run(1'b1, 1'b0, 4, -1, 20);
    chk("er_err",  m_err,  32'h20);
    chk("er_sclk", m_sclk, 32'h15554);
    chk("er_done", m_done, 32'h40000);
    chk("er_bits", sbits, 8'hA5);
    rd(0, c, r); chk("er_cfg0", c, 4'h5); chk("er_rb0", r, 4'h5);
    rd(1, c, r); chk("er_rb1", r, 4'hA);

    // start + chain_clr together: clear wins, start silently ignored
    run(1'b1, 1'b1, -1, -1, 4);
    chk("cl_rstn", m_clr,  32'h2);
    chk("cl_done", m_done, 32'h4);
    chk("cl_busy", m_busy, 32'h2);
    chk("cl_sclk", m_sclk, 32'h0);
    chk("cl_err",  m_err,  32'h0);

    // Reset in cycle 7 of a shift aborts it
    run(1'b1, 1'b0, -1, 7, 20);
    chk("rs_busy", m_busy, 32'hFE);
    chk("rs_sclk", m_sclk, 32'h54);
    chk("rs_load", m_load, 32'h0);
    chk("rs_done", m_done, 32'h0);
    rd(0, c, r); chk("rs_cfg0", c, 4'h0); chk("rs_rb0", r, 4'h0);
    rd(1, c, r); chk("rs_cfg1", c, 4'h0); chk("rs_rb1", r, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/gpio_cfg_chain_master.md
# gpio_cfg_chain_master

Parametrised master for the pad-configuration serial chain. It holds a shadow configuration word per pad and shifts the whole image into a chain of NUM_PADS GPIO control blocks. The shift runs from a programmable divided serial clock, commits it with a serial load strobe, and captures the bits returning from the chain end into a readback buffer. It sits between the SoC register bank and the pad-side chain input, so software never bit-bangs the chain.

## Interface
Parameters:
- NUM_PADS, 14: number of control blocks in the chain (1..64).
- PAD_CTRL_BITS, 16: configuration bits per pad.
- GPIO_DEFAULTS, 16'h3000: reset value of every shadow word (PAD_CTRL_BITS wide).
- CLK_DIV, 2: mclk cycles per serial-clock half period (≥1).

Ports:
- mclk  in  1  block clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- cfg_wr  in  1  shadow write strobe.
- cfg_addr  in  $clog2(NUM_PADS)  pad index for cfg_wr and for readback reads.
- cfg_wdata  in  PAD_CTRL_BITS  shadow write data.
- cfg_rdata  out  PAD_CTRL_BITS  shadow word at cfg_addr (combinational).
- rb_rdata  out  PAD_CTRL_BITS  readback word at cfg_addr (combinational).
- start  in  1  single-cycle request to shift and load the full image.
- chain_clr  in  1  single-cycle request to pulse serial_shift_rstn.
- busy  out  1  high from the cycle after an accepted request until done.
- done  out  1  one-cycle pulse when the sequence completes.
- cfg_err  out  1  one-cycle pulse when cfg_wr or a request is dropped because busy=1.
- serial_clock  out  1  chain shift clock.
- serial_load  out  1  chain load strobe.
- serial_data_out  out  1  chain data to pad 0.
- serial_data_in  in  1  chain data returned from pad NUM_PADS-1.
- serial_shift_rstn  out  1  active-low chain shift-register reset.

## Operation
- Bit order: the last pad goes first (NUM_PADS-1 down to 0), each word MSB first. After shifting, pad p holds shadow[p].
- TOTAL = NUM_PADS*PAD_CTRL_BITS bits. The bit counter is $clog2(TOTAL+1) bits wide, and the half-period counter is $clog2(CLK_DIV) bits wide (minimum 1).
- FSM states:
  - IDLE. start goes to SETUP with bit count 0. chain_clr goes to CLR.
  - SETUP. serial_clock=0 and serial_data_out = current bit. After CLK_DIV cycles, go to HIGH.
  - HIGH. serial_clock=1. serial_data_in is sampled on the last HIGH cycle and shifted into the readback shift register. After CLK_DIV cycles, go to SETUP with count+1, or to LOAD after bit TOTAL-1.
  - LOAD. serial_load=1 for CLK_DIV cycles. On exit, the readback shift register is copied into rb words, then the FSM goes to IDLE with done=1.
  - CLR. serial_shift_rstn=0 for CLK_DIV cycles. Then the FSM goes to IDLE with done=1.
- Readback captures the chain's previous contents. rb word p holds the bits that exited for pad p, ordered identically to the outgoing shift.
- If start and chain_clr are both asserted in IDLE, chain_clr wins. start is ignored without an error.
- Requests or cfg_wr arriving while busy=1 are ignored and pulse cfg_err the next cycle.
- cfg_wr in IDLE updates the shadow the next cycle. A cfg_wr in the same cycle as an accepted start is written before the image is sampled.
- cfg_addr ≥ NUM_PADS: the write is ignored, and both read data outputs are 0.
- Reset values: serial_clock=0, serial_load=0, serial_data_out=0, serial_shift_rstn=1, busy=0, done=0, cfg_err=0, FSM=IDLE, all shadow words=GPIO_DEFAULTS, all rb words=0.
- Reset mid-sequence aborts immediately: all outputs take reset values the next cycle, and the rb buffer is cleared. The chain is left with a partial image, and software must restart.

## Timing
- All outputs are registered except cfg_rdata and rb_rdata.
- start accepted at edge k:
  - busy=1 and SETUP begin at cycle k+1.
  - Bit i occupies cycles k+1+2*CLK_DIV*i to k+2*CLK_DIV*(i+1).
  - serial_clock rises at k+1+2*CLK_DIV*i+CLK_DIV.
  - LOAD begins at k+1+2*CLK_DIV*TOTAL.
  - done=1 and busy=0 occur at k+1+2*CLK_DIV*TOTAL+CLK_DIV.
- serial_data_out changes only on SETUP entry, giving CLK_DIV cycles of setup before each rising edge.
- serial_load is never high while serial_clock is high.
- CLR: busy spans CLK_DIV cycles, and done arrives at k+1+CLK_DIV.
- A new start is accepted on the done cycle, because the FSM is already IDLE.

## Test plan
Configuration: NUM_PADS=2, PAD_CTRL_BITS=4, CLK_DIV=1, so TOTAL=8.
- Reset → shadow reads 4'h0 (GPIO_DEFAULTS truncated), busy=0, serial_shift_rstn=1, serial_clock=0.
- Write pad1=4'hA, pad0=4'h5, then start at edge k → serial_data_out bit sequence 1,0,1,0,0,1,0,1 with 8 serial_clock rising edges, serial_load high at cycle k+17, done at k+18.
- Chain model preloaded with pad1=4'h3, pad0=4'hC, then run the sequence above → rb_rdata reads 4'h3 at addr1 and 4'hC at addr0, and the model then holds A/5.
- start at k, then cfg_wr at k+4 → cfg_err pulse at k+5, shadow unchanged, sequence timing unaffected.
- start and chain_clr in the same cycle → serial_shift_rstn low for 1 cycle, done one cycle later, no serial_clock edges.
- reset asserted at k+7 of a shift → serial_clock=0, busy=0, rb all 0, shadow=defaults at k+8; no serial_load pulse.
